mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between two requesters of the pipelined CPU: the instruction-fetch stage (IF) and the data-memory stage (D).
- Runs a three-state sequencer per access: grant, wait for the fixed memory latency, return the response.
- Data accesses have priority; a starvation guard protects fetch.
- Per-requester stall outputs freeze the corresponding pipeline stages until each access completes.

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_port_arbiter_if.sv | 54 +++++
 rtl/mem_port_arbiter_lat_counter.sv | 35 +++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
//============================================================================
// Module : cpu_arb_pkg
// Brief  : Shared types and default widths for the unified memory port arbiter.
// Rev    : 1.0
//============================================================================
package cpu_arb_pkg;

    localparam int C_ADDR_W   = 64;
    localparam int C_DATA_W   = 64;
    localparam int C_LAT      = 2;
    localparam int C_MAX_WAIT = 3;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WAIT = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
//============================================================================
// Module : mem_port_arbiter_if
// Brief  : Fetch, data and memory-side signals of the shared memory port.
// Rev    : 1.0
//============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = cpu_arb_pkg::C_ADDR_W,
    parameter int DATA_W = cpu_arb_pkg::C_DATA_W
) ();

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              stall_if;
    logic              stall_d;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Requesters and the memory model together form the environment side.
    modport master (
        output if_req, if_addr, if_flush,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata,
        input  if_rvalid, if_rdata, d_rvalid, d_rdata,
        input  stall_if, stall_d,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  if_req, if_addr, if_flush,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata,
        output if_rvalid, if_rdata, d_rvalid, d_rdata,
        output stall_if, stall_d,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_lat_counter.sv
`default_nettype none
//============================================================================
// Module : lat_counter
// Brief  : Loadable down-counter timing the fixed memory read latency.
// Rev    : 1.0
//============================================================================
module lat_counter #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic last
);

    localparam int             CNT_W  = $clog2(LAT + 1);
    localparam logic [CNT_W-1:0] C_LOAD = CNT_W'(LAT);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= C_LOAD;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - C_ONE;
        end
    end

    assign last = (r_cnt == C_ONE);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
//============================================================================
// Module : mem_port_arbiter
// Brief  : Grants a single-ported memory to fetch or data, D first, with a
//          starvation guard for fetch and per-requester stall outputs.
// Rev    : 1.0
//============================================================================
module mem_port_arbiter
    import cpu_arb_pkg::*;
#(
    parameter int ADDR_W   = cpu_arb_pkg::C_ADDR_W,
    parameter int DATA_W   = cpu_arb_pkg::C_DATA_W,
    parameter int LAT      = cpu_arb_pkg::C_LAT,
    parameter int MAX_WAIT = cpu_arb_pkg::C_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam int                WAIT_W         = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] C_MAX_WAIT_CNT = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] C_WAIT_ONE     = WAIT_W'(1);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    owner_t            r_owner;
    logic              r_cancel;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic              w_any_req;
    logic              w_grant;
    logic              w_grant_if;
    logic              w_last;
    logic              w_if_resp;
    logic              w_d_resp;
    logic [ADDR_W-1:0] w_mem_addr;

    assign w_any_req  = bus.if_req | bus.d_req;
    // Gating with rst keeps every strobe quiet while reset is held low.
    assign w_grant    = rst & (r_state == ARB_IDLE) & w_any_req;
    assign w_grant_if = bus.if_req & (~bus.d_req | (r_wait_cnt >= C_MAX_WAIT_CNT));

    lat_counter #(
        .LAT (LAT)
    ) u_lat_counter (
        .clk  (clk),
        .rst  (rst),
        .load (w_grant),
        .last (w_last)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_mem_addr    = '0;
        bus.mem_en    = w_grant;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        case (r_state)
            ARB_IDLE: if (w_any_req) w_state_nxt = ARB_WAIT;
            ARB_WAIT: if (w_last)    w_state_nxt = ARB_RESP;
            ARB_RESP: w_state_nxt = ARB_IDLE;
            default:  w_state_nxt = ARB_IDLE;
        endcase
        if (w_grant) begin
            if (w_grant_if) begin
                w_mem_addr = bus.if_addr;
            end else begin
                w_mem_addr    = bus.d_addr;
                bus.mem_we    = bus.d_we;
                bus.mem_wdata = bus.d_wdata;
            end
        end
        bus.mem_addr = w_mem_addr;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_owner    <= OWN_IF;
            r_cancel   <= 1'b0;
            r_wait_cnt <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            if (w_grant) begin
                r_owner  <= w_grant_if ? OWN_IF : OWN_D;
                r_cancel <= 1'b0;
                if (w_grant_if) begin
                    r_wait_cnt <= '0;
                end else if (bus.if_req && (r_wait_cnt != C_MAX_WAIT_CNT)) begin
                    r_wait_cnt <= r_wait_cnt + C_WAIT_ONE;
                end
            end
            // The memory access itself runs to completion; only the response is dropped.
            if ((r_owner == OWN_IF) && (r_state != ARB_IDLE) && bus.if_flush) begin
                r_cancel <= 1'b1;
            end
            if ((r_state == ARB_WAIT) && w_last) begin
                if (r_owner == OWN_IF) begin
                    r_if_rdata <= bus.mem_rdata;
                end else begin
                    r_d_rdata  <= bus.mem_rdata;
                end
            end
        end
    end

    assign w_if_resp = rst & (r_state == ARB_RESP) & (r_owner == OWN_IF)
                     & ~r_cancel & ~bus.if_flush & bus.if_req;
    assign w_d_resp  = rst & (r_state == ARB_RESP) & (r_owner == OWN_D) & bus.d_req;

    assign bus.if_rvalid = w_if_resp;
    assign bus.d_rvalid  = w_d_resp;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.stall_if  = bus.if_req & ~w_if_resp;
    assign bus.stall_d   = bus.d_req & ~w_d_resp;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
//============================================================================
// Module : tb_mem_port_arbiter
// Brief  : Directed scenarios with a grant/response scoreboard for the arbiter.
// Rev    : 1.0
//============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W   = 64;
    localparam int DATA_W   = 64;
    localparam int LAT      = 2;
    localparam int MAX_WAIT = 3;
    localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

    typedef struct { int cyc; bit we; logic [63:0] addr; logic [63:0] wdata; } gnt_t;
    typedef struct { int cyc; bit is_if; bit chk; logic [63:0] data; } resp_t;
    typedef struct { int due; logic [63:0] addr; } rd_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    gnt_t  gq[$];
    resp_t rq[$];
    rd_t   pq[$];
    gnt_t  g;
    resp_t r;
    rd_t   rd;
    logic [63:0] mem [logic [63:0]];

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .LAT      (LAT),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check1(input string n, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    task automatic check64(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    task automatic checki(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : JUNK;
    endfunction

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_quiet(input string tag);
        check1({tag, " mem_en"}, bus.mem_en, 1'b0);
        check1({tag, " mem_we"}, bus.mem_we, 1'b0);
        check1({tag, " if_rvalid"}, bus.if_rvalid, 1'b0);
        check1({tag, " d_rvalid"}, bus.d_rvalid, 1'b0);
        check64({tag, " mem_addr"}, bus.mem_addr, 64'h0);
        check64({tag, " mem_wdata"}, bus.mem_wdata, 64'h0);
        check64({tag, " if_rdata"}, bus.if_rdata, 64'h0);
        check64({tag, " d_rdata"}, bus.d_rdata, 64'h0);
    endtask

    // Memory model: returns read data exactly LAT cycles after the strobe, junk otherwise.
    always @(posedge clk) begin
        #1;
        while (pq.size() > 0 && pq[0].due < cyc) void'(pq.pop_front());
        if (pq.size() > 0 && pq[0].due == cyc) begin
            rd = pq.pop_front();
            bus.mem_rdata = mem_rd(rd.addr);
        end else begin
            bus.mem_rdata = JUNK;
        end
    end

    // Monitor: grants and responses are popped from the scoreboard as they appear.
    always @(negedge clk) begin
        if (bus.mem_en === 1'b1) begin
            if (bus.mem_we === 1'b1) mem[bus.mem_addr] = bus.mem_wdata;
            else pq.push_back('{cyc + LAT, bus.mem_addr});
            if (gq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected grant: addr %0h at cycle %0d, none expected", bus.mem_addr, cyc);
            end else begin
                g = gq.pop_front();
                checki("grant cycle", cyc, g.cyc);
                check64("grant addr", bus.mem_addr, g.addr);
                check1("grant we", bus.mem_we, g.we);
                if (g.we) check64("grant wdata", bus.mem_wdata, g.wdata);
            end
        end
        if (bus.if_rvalid === 1'b1 || bus.d_rvalid === 1'b1) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected rvalid: if=%0b d=%0b at cycle %0d, none expected",
                         bus.if_rvalid, bus.d_rvalid, cyc);
            end else begin
                r = rq.pop_front();
                checki("resp cycle", cyc, r.cyc);
                check1("resp if_rvalid", bus.if_rvalid, r.is_if);
                check1("resp d_rvalid", bus.d_rvalid, !r.is_if);
                if (r.chk) check64("resp data", r.is_if ? bus.if_rdata : bus.d_rdata, r.data);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int b;
        mem[64'h40]  = 64'hDEAD;
        mem[64'h80]  = 64'hCAFE;
        mem[64'h100] = 64'hBEEF;
        mem[64'h200] = 64'h1111;
        mem[64'h208] = 64'h2222;
        mem[64'h210] = 64'h3333;
        mem[64'h218] = 64'h4444;

        bus.if_req = 1'b1; bus.if_addr = 64'h40; bus.if_flush = 1'b0;
        bus.d_req = 1'b0;  bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_rdata = JUNK;

        // Reset with a fetch pending: no grant, stall follows the request.
        goto(2); #3;
        check_quiet("reset");
        check1("reset stall_if", bus.stall_if, 1'b1);
        check1("reset stall_d", bus.stall_d, 1'b0);
        goto(3);
        rst = 1'b1; bus.if_req = 1'b0;

        // A: fetch-only access.
        goto(cyc + 1); b = cyc;
        bus.if_req = 1'b1; bus.if_addr = 64'h40;
        gq.push_back('{b, 1'b0, 64'h40, 64'h0});
        rq.push_back('{b + 3, 1'b1, 1'b1, 64'hDEAD});
        for (int k = 0; k < 4; k++) begin
            goto(b + k); #3;
            check1("A stall_if", bus.stall_if, k < 3);
        end
        goto(b + 4); bus.if_req = 1'b0;

        // B: simultaneous requests, D first.
        goto(cyc + 1); b = cyc;
        bus.if_req = 1'b1; bus.if_addr = 64'h80;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'h100;
        gq.push_back('{b, 1'b0, 64'h100, 64'h0});
        gq.push_back('{b + 4, 1'b0, 64'h80, 64'h0});
        rq.push_back('{b + 3, 1'b0, 1'b1, 64'hBEEF});
        rq.push_back('{b + 7, 1'b1, 1'b1, 64'hCAFE});
        goto(b + 3); #3;
        check1("B stall_if during d_rvalid", bus.stall_if, 1'b1);
        check1("B stall_d during d_rvalid", bus.stall_d, 1'b0);
        goto(b + 4); bus.d_req = 1'b0;
        goto(b + 8); bus.if_req = 1'b0;

        // C: back-to-back loads; fetch wins the fourth arbitration.
        goto(cyc + 1); b = cyc;
        bus.if_req = 1'b1; bus.if_addr = 64'h80;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'h200;
        gq.push_back('{b, 1'b0, 64'h200, 64'h0});
        gq.push_back('{b + 4, 1'b0, 64'h208, 64'h0});
        gq.push_back('{b + 8, 1'b0, 64'h210, 64'h0});
        gq.push_back('{b + 12, 1'b0, 64'h80, 64'h0});
        gq.push_back('{b + 16, 1'b0, 64'h218, 64'h0});
        rq.push_back('{b + 3, 1'b0, 1'b1, 64'h1111});
        rq.push_back('{b + 7, 1'b0, 1'b1, 64'h2222});
        rq.push_back('{b + 11, 1'b0, 1'b1, 64'h3333});
        rq.push_back('{b + 15, 1'b1, 1'b1, 64'hCAFE});
        rq.push_back('{b + 19, 1'b0, 1'b1, 64'h4444});
        goto(b + 4);  bus.d_addr = 64'h208;
        goto(b + 8);  bus.d_addr = 64'h210;
        goto(b + 12); bus.d_addr = 64'h218;
        goto(b + 13); #3;
        check1("C stall_d while fetch owns port", bus.stall_d, 1'b1);
        goto(b + 16); bus.if_req = 1'b0;
        goto(b + 20); bus.d_req = 1'b0;

        // D: flush cancels the fetch response; pending load follows.
        goto(cyc + 1); b = cyc;
        bus.if_req = 1'b1; bus.if_addr = 64'h40;
        gq.push_back('{b, 1'b0, 64'h40, 64'h0});
        gq.push_back('{b + 4, 1'b0, 64'h100, 64'h0});
        rq.push_back('{b + 7, 1'b0, 1'b1, 64'hBEEF});
        goto(b + 1);
        bus.if_flush = 1'b1;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'h100;
        goto(b + 2); bus.if_flush = 1'b0;
        goto(b + 3); #3;
        check1("D if_rvalid after flush", bus.if_rvalid, 1'b0);
        check1("D stall_if after flush", bus.stall_if, 1'b1);
        goto(b + 4); bus.if_req = 1'b0;
        goto(b + 8); bus.d_req = 1'b0;

        // E: store then load of the same address.
        goto(cyc + 1); b = cyc;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 64'h8; bus.d_wdata = 64'h55;
        gq.push_back('{b, 1'b1, 64'h8, 64'h55});
        gq.push_back('{b + 4, 1'b0, 64'h8, 64'h0});
        rq.push_back('{b + 3, 1'b0, 1'b0, 64'h0});
        rq.push_back('{b + 7, 1'b0, 1'b1, 64'h55});
        goto(b + 4); bus.d_we = 1'b0;
        goto(b + 8); bus.d_req = 1'b0; bus.d_wdata = '0;

        // F: reset during WAIT aborts the fetch; re-request granted at once.
        goto(cyc + 1); b = cyc;
        bus.if_req = 1'b1; bus.if_addr = 64'h80;
        gq.push_back('{b, 1'b0, 64'h80, 64'h0});
        gq.push_back('{b + 3, 1'b0, 64'h80, 64'h0});
        rq.push_back('{b + 6, 1'b1, 1'b1, 64'hCAFE});
        goto(b + 1); rst = 1'b0;
        goto(b + 2); #3;
        check_quiet("midreset");
        check1("midreset stall_if", bus.stall_if, 1'b1);
        goto(b + 3); rst = 1'b1;
        goto(b + 7); bus.if_req = 1'b0;

        goto(cyc + 4);
        checki("grant queue drained", gq.size(), 0);
        checki("resp queue drained", rq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
